// File: rtl/firing_control.sv
// ============================================================================
//  Module      : firing_control
//  Description : Trigger debounce and shot/round sequencing FSM that drives
//                the firing datapath command and keeps hit/round statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module firing_control #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int FALL_CYCLES     = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       trigger,
    input  logic       round_start,
    input  logic       is_shot,
    input  logic       escape,
    input  logic [1:0] remaining_shots,
    output logic [2:0] control,
    output logic       round_active,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       timeout,
    output logic       bird_down,
    output logic [3:0] birds_hit,
    output logic [3:0] rounds_played
);

    localparam int c_DB_W   = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_TO_W   = ($clog2(TIMEOUT_CYCLES)  > 0) ? $clog2(TIMEOUT_CYCLES)  : 1;
    localparam int c_FALL_W = ($clog2(FALL_CYCLES)     > 0) ? $clog2(FALL_CYCLES)     : 1;

    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_FALL_W-1:0] c_FALL_LAST = c_FALL_W'(FALL_CYCLES - 1);

    localparam logic [2:0] c_CTL_RELOAD = 3'b000;
    localparam logic [2:0] c_CTL_HOLD   = 3'b001;
    localparam logic [2:0] c_CTL_SHOT   = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_SHOT  = 3'd2,
        S_CHECK = 3'd3,
        S_CLEAR = 3'd4,
        S_FALL  = 3'd5,
        S_EMPTY = 3'd6,
        S_ESC   = 3'd7
    } state_t;

    state_t              r_state;
    logic                r_sync1;
    logic                r_sync2;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic                r_db_level;
    logic                r_db_prev;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic [c_FALL_W-1:0] r_fall_cnt;
    logic [3:0]          r_birds_hit;
    logic [3:0]          r_rounds_played;

    logic w_fire;
    logic w_expire;
    logic w_hit;
    logic w_esc_miss;

    // Debounced level flips only after a full run of differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_cnt   <= '0;
            r_db_level <= 1'b0;
            r_db_prev  <= 1'b0;
        end else begin
            r_sync1   <= trigger;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db_level;
            if (r_sync2 != r_db_level) begin
                if (r_db_cnt == c_DB_LAST) begin
                    r_db_level <= r_sync2;
                    r_db_cnt   <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign w_fire     = r_db_level & ~r_db_prev;
    assign w_expire   = (r_state == S_ARMED) && !w_fire && (r_to_cnt == c_TO_LAST);
    assign w_hit      = (r_state == S_CHECK) && is_shot;
    assign w_esc_miss = (r_state == S_ESC) && escape;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_to_cnt   <= '0;
            r_fall_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (round_start) begin
                        r_state  <= S_ARMED;
                        r_to_cnt <= '0;
                    end
                end
                S_ARMED: begin
                    // Hold at the last value so a fire won in the expiry cycle
                    // cannot wrap the timer on return.
                    if (r_to_cnt != c_TO_LAST) begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                    if (w_fire) begin
                        r_state <= S_SHOT;
                    end else if (w_expire) begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHOT: r_state <= S_CHECK;
                S_CHECK: begin
                    if (is_shot) begin
                        r_state <= S_CLEAR;
                    end else if (remaining_shots == 2'd0) begin
                        r_state <= S_EMPTY;
                    end else begin
                        r_state <= S_ARMED;
                    end
                end
                S_CLEAR: begin
                    r_fall_cnt <= '0;
                    r_state    <= S_FALL;
                end
                S_FALL: begin
                    if (r_fall_cnt == c_FALL_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_fall_cnt <= r_fall_cnt + 1'b1;
                    end
                end
                S_EMPTY: r_state <= S_ESC;
                S_ESC: begin
                    if (escape) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_birds_hit     <= 4'd0;
            r_rounds_played <= 4'd0;
        end else begin
            if (w_hit && (r_birds_hit != 4'd15)) begin
                r_birds_hit <= r_birds_hit + 4'd1;
            end
            if (w_hit || w_expire || w_esc_miss) begin
                r_rounds_played <= r_rounds_played + 4'd1;
            end
        end
    end

    always_comb begin
        control = c_CTL_HOLD;
        case (r_state)
            S_SHOT:  control = c_CTL_SHOT;
            S_CLEAR: control = c_CTL_RELOAD;
            S_EMPTY: control = c_CTL_RELOAD;
            default: control = c_CTL_HOLD;
        endcase
    end

    assign round_active  = (r_state == S_ARMED) || (r_state == S_SHOT) || (r_state == S_CHECK);
    assign bird_down     = (r_state == S_FALL);
    assign hit_pulse     = w_hit;
    assign miss_pulse    = w_expire || w_esc_miss;
    assign timeout       = w_expire;
    assign birds_hit     = r_birds_hit;
    assign rounds_played = r_rounds_played;

endmodule

`default_nettype wire

// File: tb/tb_firing_control.sv
// ============================================================================
//  Module      : tb_firing_control
//  Description : Self-checking bench for firing_control with a small
//                behavioural firing datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_firing_control;

    logic       clk;
    logic       reset_n;
    logic       trigger;
    logic       round_start;
    logic [2:0] control;
    logic       round_active;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       timeout;
    logic       bird_down;
    logic [3:0] birds_hit;
    logic [3:0] rounds_played;

    logic [1:0] dp_shots;
    logic       dp_hit;
    logic       dp_esc;
    logic       hit_mode;

    int n_cmp, n_err, cyc;
    int n_shot, n_reload, n_hit, n_miss, n_to, n_bad;
    int first_shot_cyc, last_shot_cyc, last_miss_cyc, last_to_cyc;
    int a_cyc, down_cnt;

    typedef struct packed {
        logic       trig;
        logic       rs;
        logic [7:0] exp;   // {control, round_active, hit, miss, timeout, bird_down}
    } vec_t;

    vec_t vecs [13];

    firing_control #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (20),
        .FALL_CYCLES    (64)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .trigger        (trigger),
        .round_start    (round_start),
        .is_shot        (dp_hit),
        .escape         (dp_esc),
        .remaining_shots(dp_shots),
        .control        (control),
        .round_active   (round_active),
        .hit_pulse      (hit_pulse),
        .miss_pulse     (miss_pulse),
        .timeout        (timeout),
        .bird_down      (bird_down),
        .birds_hit      (birds_hit),
        .rounds_played  (rounds_played)
    );

    always #5 clk = ~clk;

    // Datapath model: SHOT spends a round, RELOAD refills and flags escape when empty.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dp_shots <= 2'd3;
            dp_hit   <= 1'b0;
            dp_esc   <= 1'b0;
        end else begin
            case (control)
                3'b011: begin
                    dp_shots <= dp_shots - 2'd1;
                    dp_hit   <= hit_mode;
                end
                3'b000: begin
                    dp_esc   <= (dp_shots == 2'd0) && !dp_hit;
                    dp_hit   <= 1'b0;
                    dp_shots <= 2'd3;
                end
                default: dp_esc <= 1'b0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        n_shot = 0; n_reload = 0; n_hit = 0; n_miss = 0; n_to = 0;
        first_shot_cyc = -1; last_shot_cyc = -1; last_miss_cyc = -1; last_to_cyc = -1;
    endtask

    // Observe the current cycle, drive inputs for it, then advance one clock.
    task automatic tick(input logic trig, input logic rs);
        trigger     = trig;
        round_start = rs;
        if (control == 3'b011) begin
            if (n_shot == 0) first_shot_cyc = cyc;
            n_shot++;
            last_shot_cyc = cyc;
        end
        if (control == 3'b000) n_reload++;
        if (control != 3'b000 && control != 3'b001 && control != 3'b011) n_bad++;
        if (hit_pulse) n_hit++;
        if (miss_pulse) begin n_miss++; last_miss_cyc = cyc; end
        if (timeout) begin n_to++; last_to_cyc = cyc; end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        trigger     = 1'b0;
        round_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0; reset_n = 1'b0; trigger = 1'b0; round_start = 1'b0; hit_mode = 1'b0;
        n_cmp = 0; n_err = 0; cyc = 0; n_bad = 0;
        clear_stats();

        vecs[0] = '{1'b0, 1'b1, 8'b001_0_0000};
        for (int i = 1; i <= 7; i++) vecs[i] = '{1'b1, 1'b0, 8'b001_1_0000};
        vecs[8]  = '{1'b1, 1'b0, 8'b011_1_0000};
        vecs[9]  = '{1'b1, 1'b0, 8'b001_1_1000};
        vecs[10] = '{1'b1, 1'b0, 8'b000_0_0000};
        vecs[11] = '{1'b1, 1'b0, 8'b001_0_0001};
        vecs[12] = '{1'b0, 1'b0, 8'b001_0_0001};

        // Reset values
        do_reset();
        check("reset_control", 32'(control), 32'h1);
        check("reset_flags", 32'({round_active, hit_pulse, miss_pulse, timeout, bird_down}), 32'h0);
        check("reset_counts", 32'({birds_hit, rounds_played}), 32'h0);

        // Hit round, cycle by cycle
        hit_mode = 1'b1;
        clear_stats();
        for (int i = 0; i < 13; i++) begin
            check($sformatf("hit_vec%0d", i),
                  32'({control, round_active, hit_pulse, miss_pulse, timeout, bird_down}),
                  32'(vecs[i].exp));
            tick(vecs[i].trig, vecs[i].rs);
        end
        down_cnt = 2;
        for (int k = 0; k < 200 && bird_down; k++) begin
            down_cnt++;
            tick((k >= 10) && (k < 20), 1'b0);
        end
        repeat (10) tick(1'b0, 1'b0);
        check("hit_fall_len", 32'(down_cnt), 32'd64);
        check("hit_shots_no_fall_fire", 32'(n_shot), 32'd1);
        check("hit_pulses", 32'(n_hit), 32'd1);
        check("hit_counts", 32'({birds_hit, rounds_played}), 32'h11);
        check("hit_idle", 32'({control, round_active}), 32'b001_0);

        // Glitch rejected, then the round times out
        do_reset();
        clear_stats();
        hit_mode = 1'b0;
        tick(1'b0, 1'b1);
        a_cyc = cyc;
        repeat (3) tick(1'b1, 1'b0);
        repeat (30) tick(1'b0, 1'b0);
        check("glitch_no_shot", 32'(n_shot), 32'd0);
        check("to_pulses", 32'({n_to[3:0], n_miss[3:0]}), 32'h11);
        check("to_cycle", 32'(last_to_cyc - a_cyc), 32'd19);
        check("to_miss_same", 32'(last_miss_cyc), 32'(last_to_cyc));
        check("to_counts", 32'({birds_hit, rounds_played}), 32'h01);

        // Fire lands in the expiry cycle and wins
        do_reset();
        clear_stats();
        hit_mode = 1'b1;
        tick(1'b0, 1'b1);
        a_cyc = cyc;
        repeat (13) tick(1'b0, 1'b0);
        repeat (10) tick(1'b1, 1'b0);
        repeat (100) tick(1'b0, 1'b0);
        check("exp_no_timeout", 32'(n_to), 32'd0);
        check("exp_shot_cycle", 32'(first_shot_cyc - a_cyc), 32'd20);
        check("exp_hit_only", 32'({n_shot[3:0], n_hit[3:0], n_miss[3:0]}), 32'h110);
        check("exp_counts", 32'({birds_hit, rounds_played}), 32'h11);

        // Three misses empty the gun and the bird escapes
        do_reset();
        clear_stats();
        hit_mode = 1'b0;
        tick(1'b0, 1'b1);
        for (int p = 0; p < 3; p++) begin
            repeat (4) tick(1'b1, 1'b0);
            repeat (4) tick(1'b0, 1'b0);
        end
        repeat (10) tick(1'b0, 1'b0);
        check("miss_shots", 32'(n_shot), 32'd3);
        check("miss_reloads", 32'(n_reload), 32'd1);
        check("miss_pulses", 32'({n_miss[3:0], n_hit[3:0], n_to[3:0]}), 32'h100);
        check("miss_latency", 32'(last_miss_cyc - last_shot_cyc), 32'd3);
        check("miss_counts", 32'({birds_hit, rounds_played}), 32'h01);
        check("miss_idle", 32'({control, round_active}), 32'b001_0);

        // 17 hit rounds: hits saturate, rounds wrap
        do_reset();
        clear_stats();
        hit_mode = 1'b1;
        for (int r = 0; r < 17; r++) begin
            tick(1'b0, 1'b1);
            repeat (4) tick(1'b1, 1'b0);
            repeat (80) tick(1'b0, 1'b0);
        end
        check("sat_hits", 32'(n_hit), 32'd17);
        check("sat_counts", 32'({birds_hit, rounds_played}), 32'hF1);

        // Asynchronous reset in FALL
        tick(1'b0, 1'b1);
        repeat (4) tick(1'b1, 1'b0);
        repeat (15) tick(1'b0, 1'b0);
        check("fall_before_reset", 32'(bird_down), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_down", 32'({control, round_active, bird_down}), 32'b001_0_0);
        check("async_reset_counts", 32'({birds_hit, rounds_played}), 32'h00);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        clear_stats();
        repeat (10) tick(1'b0, 1'b0);
        check("post_reset_quiet", 32'({n_shot[3:0], n_miss[3:0]}), 32'h00);
        check("legal_control", 32'(n_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
